// File: rtl/bcd_event_counter_pkg.sv
// Shared types and helpers for the BCD event counter.
//   db_state_e  : debounce FSM states
//   digit_res_t : one BCD digit plus its carry/borrow out
//   SEG_BLANK   : all segments off (active-low)
//   bcd_to_seg  : 4-bit BCD -> 7-bit active-low gfedcba
//   bcd_inc/dec : single-digit increment/decrement with carry/borrow chaining
package bcd_event_counter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StHeld,
        StReleaseWait
    } db_state_e;

    typedef struct packed {
        logic       carry;
        logic [3:0] digit;
    } digit_res_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // cin=0 passes the digit through unchanged, so the chain only ripples
    // as far as the carries actually go.
    function automatic digit_res_t bcd_inc(input logic [3:0] d, input logic cin);
        digit_res_t r;
        r.carry = 1'b0;
        r.digit = d;
        if (cin) begin
            if (d >= 4'd9) begin
                r.digit = 4'd0;
                r.carry = 1'b1;
            end else begin
                r.digit = d + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic digit_res_t bcd_dec(input logic [3:0] d, input logic bin);
        digit_res_t r;
        r.carry = 1'b0;
        r.digit = d;
        if (bin) begin
            if (d == 4'd0) begin
                r.digit = 4'd9;
                r.carry = 1'b1;
            end else begin
                r.digit = d - 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_event_counter_if.sv
// Bus between the event source/display side and the BCD event counter.
//   event_n, dir, clear             : driven by master (button side)
//   count_bcd, seg, max_flag,
//   zero_flag, limit_pulse          : driven by slave (counter)
interface bcd_event_counter_if #(
    parameter int unsigned DIGITS = 2
);
    logic                  event_n;
    logic                  dir;
    logic                  clear;
    logic [4*DIGITS-1:0]   count_bcd;
    logic [7*DIGITS-1:0]   seg;
    logic                  max_flag;
    logic                  zero_flag;
    logic                  limit_pulse;

    modport master (
        output event_n, dir, clear,
        input  count_bcd, seg, max_flag, zero_flag, limit_pulse
    );

    modport slave (
        input  event_n, dir, clear,
        output count_bcd, seg, max_flag, zero_flag, limit_pulse
    );
endinterface

// File: rtl/bcd_event_counter_debounce_pulse.sv
// Synchroniser + debounce FSM for an active-low button.
//   clk, rst : clock, async active-high reset
//   event_n  : raw asynchronous active-low input
//   accept   : one-cycle pulse, high during the cycle whose rising edge
//              completes DEBOUNCE_CYCLES stable low samples
module debounce_pulse
    import bcd_event_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic event_n,
    output logic accept
);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic            sync1_q, sync2_q;
    db_state_e       state_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= event_n;
            sync2_q <= sync1_q;
        end
    end

    // Decoded from current state so the count register updates on the very
    // edge that completes the stable run, not one cycle later.
    assign accept = !sync2_q &&
                    ((state_q == StIdle && DEBOUNCE_CYCLES == 1) ||
                     (state_q == StPressWait && cnt_q == CntLast));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!sync2_q) begin
                        cnt_q   <= CntOne;
                        state_q <= (DEBOUNCE_CYCLES == 1) ? StHeld : StPressWait;
                    end
                end
                StPressWait: begin
                    if (sync2_q) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                        if (cnt_q == CntLast) state_q <= StHeld;
                    end
                end
                StHeld: begin
                    if (sync2_q) begin
                        cnt_q   <= CntOne;
                        state_q <= (DEBOUNCE_CYCLES == 1) ? StIdle : StReleaseWait;
                    end
                end
                StReleaseWait: begin
                    if (!sync2_q) begin
                        cnt_q   <= '0;
                        state_q <= StHeld;
                    end else if (cnt_q == CntLast) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: rtl/bcd_event_counter.sv
// Multi-digit BCD event counter with debounced active-low input.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of bcd_event_counter_if
//              (event_n/dir/clear in; count_bcd/seg/flags/limit_pulse out)
module bcd_event_counter
    import bcd_event_counter_pkg::*;
#(
    parameter int unsigned DIGITS          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WRAP            = 1
) (
    input  logic               clk,
    input  logic               rst,
    bcd_event_counter_if.slave bus
);
    localparam int unsigned CW = 4 * DIGITS;

    logic                accept;
    logic [CW-1:0]       count_q, inc_val, dec_val, step_val;
    logic [DIGITS:0]     carry, borrow;
    logic [7*DIGITS-1:0] seg;
    logic [DIGITS-1:0]   nine;
    logic                limit, limit_q;

    debounce_pulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .event_n(bus.event_n),
        .accept (accept)
    );

    // Injecting 1 at digit 0 turns the chain into +1 / -1; the final
    // carry/borrow out is exactly the limit crossing.
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        digit_res_t inc_r, dec_r;
        assign inc_r              = bcd_inc(count_q[4*i +: 4], carry[i]);
        assign dec_r              = bcd_dec(count_q[4*i +: 4], borrow[i]);
        assign inc_val[4*i +: 4]  = inc_r.digit;
        assign dec_val[4*i +: 4]  = dec_r.digit;
        assign carry[i+1]         = inc_r.carry;
        assign borrow[i+1]        = dec_r.carry;
        assign seg[7*i +: 7]      = bcd_to_seg(count_q[4*i +: 4]);
        assign nine[i]            = (count_q[4*i +: 4] == 4'd9);
    end

    assign limit    = bus.dir ? borrow[DIGITS] : carry[DIGITS];
    assign step_val = bus.dir ? dec_val : inc_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            limit_q <= 1'b0;
        end else begin
            limit_q <= 1'b0;
            if (bus.clear) begin
                count_q <= '0;
            end else if (accept) begin
                limit_q <= limit;
                // Saturating mode holds the count at the limit.
                if (WRAP != 0 || !limit) count_q <= step_val;
            end
        end
    end

    assign bus.count_bcd   = count_q;
    assign bus.seg         = seg;
    assign bus.max_flag    = &nine;
    assign bus.zero_flag   = (count_q == '0);
    assign bus.limit_pulse = limit_q;
endmodule

// File: tb/tb_bcd_event_counter.sv
module tb_bcd_event_counter;
    localparam int DIG  = 2;
    localparam int DEB  = 4;
    localparam int MAXV = 99;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ev = 1'b1;
    logic dir_r = 1'b0;
    logic clr = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_event_counter_if #(.DIGITS(DIG)) bus_a ();
    bcd_event_counter_if #(.DIGITS(DIG)) bus_b ();

    assign bus_a.event_n = ev;
    assign bus_a.dir     = dir_r;
    assign bus_a.clear   = clr;
    assign bus_b.event_n = ev;
    assign bus_b.dir     = dir_r;
    assign bus_b.clear   = clr;

    bcd_event_counter #(.DIGITS(DIG), .DEBOUNCE_CYCLES(DEB), .WRAP(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    bcd_event_counter #(.DIGITS(DIG), .DEBOUNCE_CYCLES(DEB), .WRAP(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [4*DIG-1:0] to_bcd(input int v);
        logic [4*DIG-1:0] r;
        r = '0;
        for (int i = 0; i < DIG; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [7*DIG-1:0] to_seg(input int v);
        logic [7*DIG-1:0] r;
        r = '0;
        for (int i = 0; i < DIG; i++) begin
            r[7*i +: 7] = seg_pat(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Behavioural model: sync is a 2-sample delay; a press is accepted when
    // the delayed input has been low for DEB samples in a row while armed,
    // and re-arms after DEB high samples in a row. Count is a plain integer.
    logic [1:0] m_sh;
    int         m_low, m_high;
    bit         m_armed;
    int         m_val [2];
    bit         m_lp  [2];
    int         n_low, n_high;
    bit         n_acc, n_armed;
    int         n_val [2];
    bit         n_lp  [2];

    always_comb begin
        n_low   = m_sh[1] ? 0 : m_low + 1;
        n_high  = m_sh[1] ? m_high + 1 : 0;
        n_acc   = m_armed && (n_low == DEB);
        n_armed = m_armed;
        if (n_acc) n_armed = 1'b0;
        else if (!m_armed && n_high == DEB) n_armed = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_val[i] = m_val[i];
            n_lp[i]  = 1'b0;
            if (clr) begin
                n_val[i] = 0;
            end else if (n_acc) begin
                if (!dir_r) begin
                    if (m_val[i] == MAXV) begin
                        n_lp[i]  = 1'b1;
                        n_val[i] = (i == 0) ? 0 : MAXV;
                    end else n_val[i] = m_val[i] + 1;
                end else begin
                    if (m_val[i] == 0) begin
                        n_lp[i]  = 1'b1;
                        n_val[i] = (i == 0) ? MAXV : 0;
                    end else n_val[i] = m_val[i] - 1;
                end
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sh    <= 2'b11;
            m_low   <= 0;
            m_high  <= 0;
            m_armed <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_val[i] <= 0;
                m_lp[i]  <= 1'b0;
            end
        end else begin
            m_sh    <= {m_sh[0], ev};
            m_low   <= n_low;
            m_high  <= n_high;
            m_armed <= n_armed;
            for (int i = 0; i < 2; i++) begin
                m_val[i] <= n_val[i];
                m_lp[i]  <= n_lp[i];
            end
        end
    end

    task automatic cmp_inst(input string tag, input logic [4*DIG-1:0] cnt,
                            input logic [7*DIG-1:0] sg, input logic mx, input logic zr,
                            input logic lp, input int v, input bit elp);
        chk({tag, " count"}, 64'(cnt), 64'(to_bcd(v)));
        chk({tag, " seg"}, 64'(sg), 64'(to_seg(v)));
        chk({tag, " max_flag"}, 64'(mx), 64'(v == MAXV));
        chk({tag, " zero_flag"}, 64'(zr), 64'(v == 0));
        chk({tag, " limit_pulse"}, 64'(lp), 64'(elp));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cmp_inst("A", bus_a.count_bcd, bus_a.seg, bus_a.max_flag, bus_a.zero_flag,
                     bus_a.limit_pulse, m_val[0], m_lp[0]);
            cmp_inst("B", bus_b.count_bcd, bus_b.seg, bus_b.max_flag, bus_b.zero_flag,
                     bus_b.limit_pulse, m_val[1], m_lp[1]);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Returns 1 time unit after the accept edge (edge DEB+1 after ev falls).
    task automatic press_to_accept();
        ev = 1'b0;
        repeat (DEB + 2) @(posedge clk);
        #1;
    endtask

    task automatic release_ev();
        #1;
        ev = 1'b1;
        step(DEB + 4);
    endtask

    task automatic press();
        press_to_accept();
        release_ev();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int run;
        #1;
        chk("reset count", 64'(bus_a.count_bcd), 64'h00);
        chk("reset seg", 64'(bus_a.seg), 64'(14'b1000000_1000000));
        chk("reset zero_flag", 64'(bus_a.zero_flag), 64'd1);
        chk("reset max_flag", 64'(bus_a.max_flag), 64'd0);
        chk("reset limit_pulse", 64'(bus_a.limit_pulse), 64'd0);
        step(2);
        rst = 1'b0;
        step(3);

        // Held low for 20 cycles: exactly one count, landing on edge 5.
        ev = 1'b0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (e == 4) chk("latency edge4", 64'(bus_a.count_bcd), 64'h00);
            if (e == 5) chk("latency edge5", 64'(bus_a.count_bcd), 64'h01);
        end
        chk("held no recount", 64'(bus_a.count_bcd), 64'h01);
        release_ev();

        // Glitch shorter than the debounce window.
        ev = 1'b0;
        step(3);
        ev = 1'b1;
        step(10);
        chk("glitch rejected", 64'(bus_a.count_bcd), 64'h01);

        repeat (8) press();
        chk("count 09", 64'(bus_a.count_bcd), 64'h09);
        press();
        chk("carry 09->10", 64'(bus_a.count_bcd), 64'h10);
        repeat (9) press();
        chk("count 19", 64'(bus_a.count_bcd), 64'h19);
        repeat (23) press();
        chk("count 42", 64'(bus_a.count_bcd), 64'h42);

        // clear coinciding with the accept edge wins and consumes the press.
        ev = 1'b0;
        repeat (DEB + 1) @(posedge clk);
        #2;
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clear wins count", 64'(bus_a.count_bcd), 64'h00);
        chk("clear wins limit", 64'(bus_a.limit_pulse), 64'd0);
        #1;
        clr = 1'b0;
        release_ev();
        chk("press consumed", 64'(bus_a.count_bcd), 64'h00);
        press();
        chk("second press", 64'(bus_a.count_bcd), 64'h01);

        // Down across zero.
        dir_r = 1'b1;
        press();
        chk("down to 00", 64'(bus_a.count_bcd), 64'h00);
        press_to_accept();
        chk("wrap down A", 64'(bus_a.count_bcd), 64'h99);
        chk("wrap down A lp", 64'(bus_a.limit_pulse), 64'd1);
        chk("sat down B", 64'(bus_b.count_bcd), 64'h00);
        chk("sat down B lp", 64'(bus_b.limit_pulse), 64'd1);
        @(posedge clk);
        #1;
        chk("lp one cycle", 64'(bus_a.limit_pulse), 64'd0);
        release_ev();

        // Up across 99 in both modes.
        dir_r = 1'b0;
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        repeat (99) press();
        chk("A at 99", 64'(bus_a.count_bcd), 64'h99);
        chk("B at 99", 64'(bus_b.count_bcd), 64'h99);
        chk("B max_flag", 64'(bus_b.max_flag), 64'd1);
        press_to_accept();
        chk("wrap up A", 64'(bus_a.count_bcd), 64'h00);
        chk("wrap up A lp", 64'(bus_a.limit_pulse), 64'd1);
        chk("sat up B", 64'(bus_b.count_bcd), 64'h99);
        chk("sat up B lp", 64'(bus_b.limit_pulse), 64'd1);
        @(posedge clk);
        #1;
        chk("sat lp one cycle", 64'(bus_b.limit_pulse), 64'd0);
        release_ev();

        // Random bursts, glitches, direction changes and clears.
        run = 0;
        for (int c = 0; c < 800; c++) begin
            if (run == 0) begin
                ev  = ~ev;
                run = int'($urandom_range(1, 9));
            end
            run--;
            if ($urandom_range(0, 15) == 0) dir_r = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 49) == 0);
            step(1);
        end
        clr   = 1'b0;
        ev    = 1'b1;
        dir_r = 1'b0;
        step(10);

        // Reset in the middle of a debounce run.
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        press();
        chk("pre-reset count", 64'(bus_a.count_bcd), 64'h01);
        ev = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst count", 64'(bus_a.count_bcd), 64'h00);
        chk("mid rst seg", 64'(bus_a.seg), 64'(14'b1000000_1000000));
        chk("mid rst zero", 64'(bus_a.zero_flag), 64'd1);
        chk("mid rst lp", 64'(bus_a.limit_pulse), 64'd0);
        ev = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);
        press();
        chk("after rst press", 64'(bus_a.count_bcd), 64'h01);
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_event_counter.md
# bcd_event_counter

Parametrised multi-digit BCD event counter for board-level push-button and sensor inputs. It synchronises and debounces an active-low event input and produces exactly one count per accepted press. The count runs up or down with wrap or saturate at the limits, and drives one active-low 7-segment display per decimal digit. It succeeds the single-digit hex event counter for designs that need multi-digit decimal display and glitch rejection.

## Interface
- DIGITS, 2: number of BCD digits (1..8).
- DEBOUNCE_CYCLES, 4: consecutive stable samples required to accept a press or a release (>=1).
- WRAP, 1: 1 = wrap at limits; 0 = saturate at limits.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- event_n  input  1  asynchronous active-low event/button.
- dir  input  1  0 = count up, 1 = count down; sampled on the accept edge.
- clear  input  1  synchronous clear of the count to 0.
- count_bcd  output  4*DIGITS  count; digit i in bits [4i+3:4i], digit 0 least significant.
- seg  output  7*DIGITS  active-low segments (gfedcba) for digit i in bits [7i+6:7i].
- max_flag  output  1  high while every digit is 9.
- zero_flag  output  1  high while every digit is 0.
- limit_pulse  output  1  one-cycle pulse when an accepted event crosses a limit (9..9 up, or 0..0 down).

## Operation
- Input path: 2-flop synchroniser on event_n, then a debounce FSM. The FSM has a stable-sample counter of width clog2(DEBOUNCE_CYCLES+1).
- FSM states and transitions:
  - IDLE: synchronised input low -> PRESS_WAIT with counter = 1.
  - PRESS_WAIT: input low -> counter increments; on reaching DEBOUNCE_CYCLES -> HELD with accept. Input high -> IDLE, counter cleared.
  - HELD: input high -> RELEASE_WAIT with counter = 1.
  - RELEASE_WAIT: input high for DEBOUNCE_CYCLES consecutive samples -> IDLE. Input low -> HELD.
- One accept per press. Holding the input low never re-counts.
- Accept with dir=0: BCD increment. A digit of 9 becomes 0 and carries.
- Accept with dir=1: BCD decrement. A digit of 0 becomes 9 and borrows.
- Limits:
  - Up from all-9s: WRAP=1 -> all-0s; WRAP=0 -> hold at all-9s.
  - Down from all-0s: WRAP=1 -> all-9s; WRAP=0 -> hold at all-0s.
  - limit_pulse asserts on a limit crossing in both modes.
- clear and accept in the same cycle: clear wins, count = 0, limit_pulse = 0. The debounce FSM still advances, so the press is consumed.
- clear does not affect the synchroniser or the FSM.
- Digit values 10..15 cannot occur. The decoder maps them to 7'b1111111.
- Segment patterns 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.

## Timing
- Reset values:
  - count_bcd = 0; every seg digit = 7'b1000000.
  - zero_flag = 1, max_flag = 0, limit_pulse = 0.
  - FSM = IDLE; synchroniser flops = 1 (released); counter = 0.
- Latency: event_n first sampled low at edge 0 -> synchronised low after edge 1 -> accept at edge 1+DEBOUNCE_CYCLES. count_bcd and limit_pulse update on that same edge. For the default, the count changes at edge 5.
- seg, max_flag and zero_flag are combinational from count_bcd (zero added latency). limit_pulse is registered.
- Low pulses shorter than DEBOUNCE_CYCLES synchronised samples are rejected.
- rst asserted mid-debounce or mid-press returns every register to its reset value immediately. A press still held at rst deassertion is counted once, after the full debounce.

## Structure
- Package bcd_event_counter_pkg holds:
  - the debounce state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT);
  - SEG_BLANK and the function bcd_to_seg (4-bit -> 7-bit active-low);
  - the helper functions bcd_inc and bcd_dec on a single digit, returning digit plus carry/borrow.
- Sub-module debounce_pulse contains the synchroniser, the FSM and the counter. Parameter: DEBOUNCE_CYCLES. Outputs: a one-cycle accept pulse.
- Top level: count register, generate loop over digits for carry/borrow chain and segment decode, flags.

## Test plan
- Reset, DIGITS=2: count_bcd=8'h00, seg=14'b1000000_1000000, zero_flag=1.
- Hold event_n low 20 cycles, dir=0, DEBOUNCE_CYCLES=4: count becomes 8'h01 exactly at edge 5. No further change while held.
- 3-cycle low glitch: no count change. 10 clean presses from 8'h09 with dir=0: 8'h19 with the 09->10 carry correct.
- WRAP=1 at 8'h99 up: 8'h00 with limit_pulse high for one cycle. WRAP=0 at 8'h99 up: stays 8'h99, limit_pulse pulses. WRAP=1 at 8'h00 down: 8'h99.
- clear on the accept edge at 8'h42: count=8'h00, limit_pulse=0. A second press is needed for 8'h01.
- rst asserted during PRESS_WAIT with counter=2: all outputs at reset values immediately. Release then re-press: count=8'h01.
